// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: two synchronized/debounced buttons feed a
// four-state FSM that drives the timer run enable, its clear pulse and the display mux.

module sw_debounce #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  // Any return of the synchronized level to the accepted level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_db & ~r_db_d;

endmodule

module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [23:0] time_in,
  output logic        start,
  output logic        timer_clr_n,
  output logic [23:0] disp,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  logic        w_ss;
  logic        w_lr;
  state_t      w_next;
  logic        w_clr;
  logic        w_cap;

  state_t      r_state;
  logic        r_start;
  logic        r_clr_n;
  logic [23:0] r_lap;
  logic [23:0] r_disp;

  sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (btn_ss),
    .o_press (w_ss)
  );

  sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (btn_lr),
    .o_press (w_lr)
  );

  // Start/stop has priority: a lap/reset press in the same cycle is dropped.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss)      w_next = S_RUN;
        else if (w_lr) w_clr  = 1'b1;
      end
      S_RUN: begin
        if (w_ss) begin
          w_next = S_PAUSE;
        end else if (w_lr) begin
          w_next = S_LAP;
          w_cap  = 1'b1;
        end
      end
      S_LAP: begin
        if (w_ss)      w_next = S_PAUSE;
        else if (w_lr) w_next = S_RUN;
      end
      S_PAUSE: begin
        if (w_ss) begin
          w_next = S_RUN;
        end else if (w_lr) begin
          w_next = S_IDLE;
          w_clr  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_clr_n <= 1'b1;
      r_lap   <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == S_RUN) || (w_next == S_LAP);
      r_clr_n <= ~w_clr;
      if (w_cap) r_lap <= time_in;
      // On the entry edge the lap register is only just loading, so show time_in directly.
      if (w_next == S_LAP) r_disp <= w_cap ? time_in : r_lap;
      else                 r_disp <= time_in;
    end
  end

  assign start       = r_start;
  assign timer_clr_n = r_clr_n;
  assign disp        = r_disp;
  assign mode        = r_state;

endmodule
